// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg
// Shared constants and helpers for the BADGE_V3 LED matrix scanner.
//   LED_ROWS / LED_COLS : physical matrix geometry (3 anode rows x 11 cathode columns)
//   LED_ADDR_W          : width of the brightness write address (row*COLS+col)
//   led_addr()          : pack (row, col) into a write address
//   cnt_w()             : counter width for a count of 0..max_count-1, never below 1
package led_matrix_pkg;

  localparam int LED_ROWS   = 3;
  localparam int LED_COLS   = 11;
  localparam int LED_ADDR_W = 6;

  function automatic logic [LED_ADDR_W-1:0] led_addr(input int unsigned row,
                                                     input int unsigned col);
    return LED_ADDR_W'(row * LED_COLS + col);
  endfunction

  // A terminal count of 0 still needs a 1-bit register to hold it.
  function automatic int cnt_w(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/led_scan_regfile.sv
// led_scan_regfile
// Per-LED PWM brightness store with one write port and one row-wide read port.
//   clk, reset : rising-edge clock, synchronous active-high reset (clears all entries)
//   wr_en      : single-cycle write strobe
//   wr_addr    : LED index row*COLS+col; indices >= ROWS*COLS are dropped silently
//   wr_data    : brightness value
//   rd_row     : row to read
//   rd_data    : COLS brightness values of rd_row, combinational
module led_scan_regfile
  import led_matrix_pkg::*;
#(
  parameter int ROWS     = LED_ROWS,
  parameter int COLS     = LED_COLS,
  parameter int PWM_BITS = 4,
  parameter int ROW_W    = cnt_w(ROWS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [LED_ADDR_W-1:0]              wr_addr,
  input  logic [PWM_BITS-1:0]                wr_data,
  input  logic [ROW_W-1:0]                   rd_row,
  output logic [COLS-1:0][PWM_BITS-1:0]      rd_data
);

  localparam int N = ROWS * COLS;

  logic [N-1:0][PWM_BITS-1:0]             mem_q;
  logic [ROWS-1:0][COLS-1:0][PWM_BITS-1:0] row_view;
  logic                                   wr_hit;

  // Range check done once here so the per-entry decode below is a plain compare.
  assign wr_hit = wr_en && (32'(wr_addr) < N);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_hit && (32'(wr_addr) == i)) mem_q[i] <= wr_data;
      end
    end
  end

  // Regroup the flat store by row so the read mux indexes with a row-sized select.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign row_view[r][c] = mem_q[r*COLS + c];
    end
  end

  assign rd_data = row_view[rd_row];

endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan
// Time-multiplexed PWM driver for the BADGE_V3 3x11 LED matrix. Each row is
// preceded by a blanking gap, then shown for (2^PWM_BITS-1) PWM steps of
// DWELL_CYCLES cycles each, using a shadow copy of that row's brightness.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   wr_en      : brightness write strobe
//   wr_addr    : LED index row*COLS+col
//   wr_data    : brightness, 0 = off, all-ones = always on while the row is shown
//   ledc       : cathode column drive, 1 = lit, registered
//   leda       : anode row select, one-hot or zero, registered
//   row_sync   : one-cycle pulse in the first lit cycle of row 0 (frame start)
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = LED_ROWS,
  parameter int COLS         = LED_COLS,
  parameter int PWM_BITS     = 4,
  parameter int DWELL_CYCLES = 64,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [LED_ADDR_W-1:0] wr_addr,
  input  logic [PWM_BITS-1:0]   wr_data,
  output logic [COLS-1:0]       ledc,
  output logic [ROWS-1:0]       leda,
  output logic                  row_sync
);

  localparam int STEPS = (1 << PWM_BITS) - 1;
  localparam int ROW_W = cnt_w(ROWS);
  localparam int DW_W  = cnt_w(DWELL_CYCLES);
  localparam int BL_W  = cnt_w(BLANK_CYCLES);

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_ON    = 1'b1;

  localparam logic [ROW_W-1:0]    ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [DW_W-1:0]     DW_LAST   = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0]     BL_LAST   = BL_W'(BLANK_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] STEP_LAST = PWM_BITS'(STEPS - 1);
  localparam logic [ROWS-1:0]     ROW0_SEL  = ROWS'(1);

  logic                          state_q,     state_d;
  logic [ROW_W-1:0]              row_q,       row_d;
  logic [BL_W-1:0]               blank_cnt_q, blank_cnt_d;
  logic [DW_W-1:0]               dwell_cnt_q, dwell_cnt_d;
  logic [PWM_BITS-1:0]           step_q,      step_d;
  logic [COLS-1:0][PWM_BITS-1:0] shadow_q,    shadow_d;
  logic [COLS-1:0]               ledc_q,      ledc_d;
  logic [ROWS-1:0]               leda_q,      leda_d;
  logic                          row_sync_q,  row_sync_d;

  logic [COLS-1:0][PWM_BITS-1:0] row_vals;

  led_scan_regfile #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .PWM_BITS (PWM_BITS),
    .ROW_W    (ROW_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_row  (row_q),
    .rd_data (row_vals)
  );

  // Scan sequencing. Counters are cleared on entry to the state that uses them
  // and only ever compared for equality against their terminal value.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    blank_cnt_d = blank_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    step_d      = step_q;
    shadow_d    = shadow_q;
    row_sync_d  = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (blank_cnt_q == BL_LAST) begin
          // Snapshot the row here so writes during ON never tear the PWM pattern.
          // A write landing on this same edge is not seen until the next scan.
          state_d     = ST_ON;
          shadow_d    = row_vals;
          step_d      = '0;
          dwell_cnt_d = '0;
          row_sync_d  = (row_q == '0);
        end else begin
          blank_cnt_d = blank_cnt_q + BL_W'(1);
        end
      end
      default: begin // ST_ON
        if (dwell_cnt_q == DW_LAST) begin
          dwell_cnt_d = '0;
          if (step_q == STEP_LAST) begin
            state_d     = ST_BLANK;
            blank_cnt_d = '0;
            row_d       = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
          end else begin
            step_d = step_q + PWM_BITS'(1);
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DW_W'(1);
        end
      end
    endcase
  end

  // Pin drive is computed from the next state so the registered outputs line
  // up cycle-for-cycle with the state they describe.
  always_comb begin
    leda_d = '0;
    ledc_d = '0;
    if (state_d == ST_ON) begin
      leda_d = ROW0_SEL << row_d;
      for (int c = 0; c < COLS; c++) begin
        ledc_d[c] = (step_d < shadow_d[c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BLANK;
      row_q       <= '0;
      blank_cnt_q <= '0;
      dwell_cnt_q <= '0;
      step_q      <= '0;
      shadow_q    <= '0;
      ledc_q      <= '0;
      leda_q      <= '0;
      row_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      blank_cnt_q <= blank_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      step_q      <= step_d;
      shadow_q    <= shadow_d;
      ledc_q      <= ledc_d;
      leda_q      <= leda_d;
      row_sync_q  <= row_sync_d;
    end
  end

  assign ledc     = ledc_q;
  assign leda     = leda_q;
  assign row_sync = row_sync_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with DWELL=2, BLANK=1, PWM_BITS=4:
// row period 31 (30 ON + 1 BLANK), frame period 93. Outputs sampled on negedge,
// inputs driven right after the sample.
module tb_led_matrix_scan;
  import led_matrix_pkg::*;

  localparam int ROWS  = 3;
  localparam int COLS  = 11;
  localparam int ROWP  = 31;
  localparam int FRAME = 93;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wr_en = 1'b0;
  logic [5:0]      wr_addr = '0;
  logic [3:0]      wr_data = '0;
  logic [COLS-1:0] ledc;
  logic [ROWS-1:0] leda;
  logic            row_sync;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   synced;
  logic [3:0] bri [ROWS*COLS];

  always #5 clk = ~clk;

  led_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .PWM_BITS(4), .DWELL_CYCLES(2), .BLANK_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ledc(ledc), .leda(leda), .row_sync(row_sync)
  );

  // Expected pins at frame offset i (i=0 is the row_sync cycle).
  function automatic logic [COLS-1:0] exp_ledc(input int i);
    logic [COLS-1:0] v;
    int r, p;
    v = '0;
    r = i / ROWP;
    p = i % ROWP;
    if (p != ROWP - 1)
      for (int c = 0; c < COLS; c++) v[c] = ((p / 2) < int'(bri[r*COLS + c]));
    return v;
  endfunction

  function automatic logic [ROWS-1:0] exp_leda(input int i);
    logic [ROWS-1:0] one;
    one = 3'b001;
    return ((i % ROWP) == ROWP - 1) ? '0 : (one << (i / ROWP));
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < ROWS*COLS; k++) bri[k] = '0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [3:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < 6'd33) bri[a] = d;
  endtask

  // Advance to the next frame start; leaves the bench at its first sample.
  task automatic sync_frame();
    synced = 1'b0;
    for (int k = 0; k < 200 && !synced; k++) begin
      @(negedge clk);
      if (row_sync === 1'b1) synced = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (ledc !== '0 || leda !== '0 || row_sync !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d ledc=%h leda=%b sync=%b want 0", k, ledc, leda, row_sync);
      end
    end
    reset = 1'b0;
    for (int k = 0; k < ROWS*COLS; k++) bri[k] = '0;
    @(negedge clk);
    n_tests++;
    if (leda !== 3'b001 || row_sync !== 1'b1 || ledc !== '0) begin
      n_fail++;
      $display("FAIL reset_first_on leda=%b sync=%b ledc=%h want 001/1/000", leda, row_sync, ledc);
    end
    @(negedge clk);
    n_tests++;
    if (leda !== 3'b001 || row_sync !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sync_pulse leda=%b sync=%b want 001/0", leda, row_sync);
    end
  endtask

  task automatic test_full_bright();
    do_reset();
    wr(led_addr(0, 8), 4'd15);
    sync_frame();
    n_tests++;
    if (!synced) begin n_fail++; $display("FAIL full_sync no row_sync seen"); end
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if (ledc !== exp_ledc(i) || leda !== exp_leda(i) || row_sync !== logic'(i == 0)) begin
        n_fail++;
        $display("FAIL full_bright i=%0d ledc=%h want %h leda=%b want %b sync=%b",
                 i, ledc, exp_ledc(i), leda, exp_leda(i), row_sync);
      end
    end
  endtask

  task automatic test_half_duty();
    int lit;
    lit = 0;
    do_reset();
    wr(led_addr(1, 1), 4'd8);
    sync_frame();
    n_tests++;
    if (!synced) begin n_fail++; $display("FAIL half_sync no row_sync seen"); end
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= ROWP && i < 2*ROWP - 1 && ledc[1] === 1'b1) lit++;
      n_tests++;
      if (ledc !== exp_ledc(i) || leda !== exp_leda(i)) begin
        n_fail++;
        $display("FAIL half_duty i=%0d ledc=%h want %h leda=%b want %b",
                 i, ledc, exp_ledc(i), leda, exp_leda(i));
      end
    end
    n_tests++;
    if (lit != 16) begin
      n_fail++;
      $display("FAIL half_duty_count lit=%0d want 16", lit);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    wr(6'd33, 4'd15);
    wr(6'd63, 4'd15);
    sync_frame();
    n_tests++;
    if (!synced) begin n_fail++; $display("FAIL oor_sync no row_sync seen"); end
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if (ledc !== '0 || leda !== exp_leda(i)) begin
        n_fail++;
        $display("FAIL out_of_range i=%0d ledc=%h want 000 leda=%b want %b",
                 i, ledc, leda, exp_leda(i));
      end
    end
  endtask

  // Write row 2 col 0 mid-way through row 2 ON: dark now, fully lit next frame.
  task automatic test_active_write();
    logic [COLS-1:0] want;
    do_reset();
    sync_frame();
    n_tests++;
    if (!synced) begin n_fail++; $display("FAIL active_sync no row_sync seen"); end
    for (int j = 0; j < 2*FRAME; j++) begin
      if (j > 0) @(negedge clk);
      want = (j / FRAME == 1 && (j % FRAME) >= 2*ROWP && (j % FRAME) < 3*ROWP - 1)
             ? 11'h001 : 11'h000;
      n_tests++;
      if (ledc !== want) begin
        n_fail++;
        $display("FAIL active_write j=%0d ledc=%h want %h", j, ledc, want);
      end
      if (j == 70) begin wr_addr = led_addr(2, 0); wr_data = 4'd15; wr_en = 1'b1; end
      if (j == 71) wr_en = 1'b0;
    end
  endtask

  // Write row 1 on the very edge that shadows row 1: old value shown, new next frame.
  task automatic test_shadow_race();
    logic [COLS-1:0] want;
    do_reset();
    sync_frame();
    n_tests++;
    if (!synced) begin n_fail++; $display("FAIL race_sync no row_sync seen"); end
    for (int j = 0; j < 2*FRAME; j++) begin
      if (j > 0) @(negedge clk);
      want = (j / FRAME == 1 && (j % FRAME) >= ROWP && (j % FRAME) < 2*ROWP - 1)
             ? 11'h001 : 11'h000;
      n_tests++;
      if (ledc !== want) begin
        n_fail++;
        $display("FAIL shadow_race j=%0d ledc=%h want %h", j, ledc, want);
      end
      if (j == 30) begin wr_addr = led_addr(1, 0); wr_data = 4'd15; wr_en = 1'b1; end
      if (j == 31) wr_en = 1'b0;
    end
  endtask

  task automatic test_reset_midscan();
    do_reset();
    wr(led_addr(0, 5), 4'd15);
    wr(led_addr(1, 4), 4'd15);
    sync_frame();
    n_tests++;
    if (!synced) begin n_fail++; $display("FAIL mid_sync no row_sync seen"); end
    repeat (40) @(negedge clk);
    n_tests++;
    if (ledc !== 11'h010 || leda !== 3'b010) begin
      n_fail++;
      $display("FAIL mid_pre ledc=%h leda=%b want 010/010", ledc, leda);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ledc !== '0 || leda !== '0 || row_sync !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset ledc=%h leda=%b sync=%b want 0", ledc, leda, row_sync);
    end
    reset = 1'b0;
    for (int k = 0; k < ROWS*COLS; k++) bri[k] = '0;
    @(negedge clk);
    n_tests++;
    if (leda !== 3'b001 || row_sync !== 1'b1 || ledc !== '0) begin
      n_fail++;
      $display("FAIL mid_restart leda=%b sync=%b ledc=%h want 001/1/000", leda, row_sync, ledc);
    end
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      n_tests++;
      if (ledc !== '0 || leda !== exp_leda(i)) begin
        n_fail++;
        $display("FAIL mid_cleared i=%0d ledc=%h want 000 leda=%b want %b",
                 i, ledc, leda, exp_leda(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_bright();
    test_half_duty();
    test_out_of_range();
    test_active_write();
    test_shadow_race();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
